instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Reader side of the 16-entry program ROM. Drives the ROM address from a program counter and captures the combinational instruction word.
- Buffers fetched words, with their PCs, in a small prefetch FIFO. Hands them to the decoder over a valid/ready handshake.
- Supports PC redirect for jumps/branches. Sits between program ROM and decode/execute.

Parameters:
- ADDR_W, 4, program counter / ROM address width (16 words)
- INST_W, 16, instruction word width
- FIFO_DEPTH, 2, prefetch entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new ROM fetches; 0 freezes PC, FIFO still drains
- rom_addr  out  ADDR_W  address to program ROM, equals pc register
- rom_inst  in  INST_W  ROM instruction at rom_addr, same cycle (combinational ROM)
- inst_data  out  INST_W  FIFO head instruction
- inst_pc  out  ADDR_W  PC of FIFO head
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  decoder accepts head this cycle
- redirect_valid  in  1  load new PC and flush, one-cycle pulse
- redirect_pc  in  ADDR_W  target PC
- halted  out  1  fetch stopped at end of program (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: pc=0, FIFO count=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0, rom_addr=0.
- rom_addr is always the pc register (registered, no comb path from inputs).
- pop = inst_valid & inst_ready.
- push = fetch_en & !halted & !redirect_valid & (count<FIFO_DEPTH | pop).
- On push: enqueue {pc, rom_inst}; pc <= pc+1, wrapping modulo 2^ADDR_W (15 -> 0).
- Latency: word at pc appears on inst_data one cycle after it is presented on rom_addr, if the FIFO was empty. First valid word after reset release is pc 0 on the cycle after the first enabled edge.
- Full (count=FIFO_DEPTH) without pop: no push, pc holds.
- Full with pop: push and pop together, count unchanged.
- Empty: inst_valid=0; inst_ready ignored.
- Simultaneous push+pop at any count: count unchanged, order preserved.
- Redirect has priority over push. The handshake in the redirect cycle is honoured: the head is delivered if pop. Next edge: FIFO flushed (count=0), pc <= redirect_pc, halted <= 0. inst_valid is 0 the cycle after redirect; the target word is valid the cycle after that.
- fetch_en=0: pc and push frozen; pops continue until empty.
- Reset asserted mid-operation: immediate asynchronous return to reset values; in-flight FIFO contents are discarded.
- FSM: RUN, HALTED. HALTED is only reachable with the optional feature. Without the feature the state is constant RUN.

Optional Feature:
- Macro FETCH_HALT_ON_WRAP_EN.
- Defined: a push of pc = 2^ADDR_W-1 moves the FSM to HALTED. halted=1, no further pushes, pc stays at the last value, and the FIFO drains normally. Only redirect_valid (back to RUN) or reset leaves HALTED.
- Undefined: pc wraps 15 -> 0 and fetching continues; halted is tied 0.

Decomposition:
- Shared package proc_pkg: ADDR_W, INST_W, and opcode constants OP_ADDI=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0011, OP_OUT=4'b1111. The fetch logic does not decode opcodes; the constants are for the bench and decoder.
- Sub-module fetch_fifo (synchronous FIFO, width ADDR_W+INST_W, depth FIFO_DEPTH, push/pop/flush, count, async active-low reset). Top contains pc, push/pop logic and the FSM.

Test Plan:
- Reset release, fetch_en=1, inst_ready=1 with ROM image from the team program -> inst_pc 0,1,2,... on consecutive cycles from cycle 1. inst_data at pc 0 = 16'h1209, at pc 1 = 16'h1407.
- inst_ready=0 for 5 cycles -> count saturates at 2, rom_addr holds at 2. Then ready=1 -> pcs 0,1,2 delivered in order, none lost or duplicated.
- Redirect to pc 8 while FIFO holds pcs 3,4 and ready=1 -> pc 3 delivered in the redirect cycle, pc 4 dropped, no valid the next cycle, then inst_pc=8, inst_data=16'h3C00.
- Wrap without macro: run past pc 15 -> inst_pc sequence 14,15,0,1; halted stays 0.
- With FETCH_HALT_ON_WRAP_EN: after push of pc 15, halted=1, FIFO drains, inst_valid=0. Then redirect to 0 -> halted=0 and pc 0 is delivered.
- Assert rst_n low mid-stream with count=2 -> outputs zero asynchronously, before the next clk edge; restart fetches from pc 0.

Source files
------------

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the small processor slice: program counter / ROM
// address width, instruction width, default prefetch depth, the opcode
// encodings used by the decoder and benches, and the fetch FSM state type.
// The fetch unit itself never decodes opcodes.
// Ports: none (package).
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int ADDR_W     = 4;
    localparam int INST_W     = 16;
    localparam int FIFO_DEPTH = 2;

    // Opcodes live in inst[15:12].
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous first-word-fall-through FIFO holding prefetched {pc, inst}
// words. The head entry is visible on rd_data whenever count is non-zero.
// flush empties the FIFO on the next edge and takes priority over push/pop.
// The caller guarantees push only when not full (or popping in the same
// cycle) and pop only when non-empty.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   push/wr_data enqueue wr_data
//   pop          dequeue head
//   flush        discard all entries
//   rd_data      head entry
//   count        number of valid entries (0..DEPTH)
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own. When full,
    // wr_ptr equals rd_ptr; a simultaneous push+pop overwrites the slot that
    // is being read out on this same edge, which is safe because the read is
    // combinational from the pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Reader side of the 16-word program ROM. The pc register drives the ROM
// address directly; the combinational ROM word is captured together with its
// pc into a small prefetch FIFO and handed to decode over valid/ready.
// A one-cycle redirect pulse flushes the FIFO and reloads pc.
//
// Optional feature (macro FETCH_HALT_ON_WRAP_EN): pushing the last address
// (2^ADDR_W-1) moves the FSM to HALTED, stopping further fetches until a
// redirect or reset. Without the macro pc simply wraps and halted stays 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_en          allow new fetches (0 freezes pc, FIFO still drains)
//   rom_addr          program ROM address (= pc register)
//   rom_inst          ROM word at rom_addr, same cycle
//   inst_data/inst_pc FIFO head instruction and its pc
//   inst_valid        FIFO non-empty
//   inst_ready        decoder accepts the head this cycle
//   redirect_valid    load redirect_pc and flush (one-cycle pulse)
//   redirect_pc       redirect target
//   halted            fetch stopped at end of program
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int ADDR_W     = 4,
    parameter int INST_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    import proc_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0]        pc;
    fetch_state_t             state;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W+INST_W-1:0] head;
    logic                     push;
    logic                     pop;

    assign rom_addr   = pc;
    assign inst_valid = (count != '0);
    assign halted     = (state == HALTED);
    assign pop        = inst_valid & inst_ready;

    // A full FIFO can still accept a word when the head leaves in the same
    // cycle. Redirect wins over push so the stale word at pc is never queued.
    assign push = fetch_en & ~halted & ~redirect_valid &
                  ((count < CNT_W'(FIFO_DEPTH)) | pop);

    assign {inst_pc, inst_data} = head;

    // pc and FSM. Redirect reloads pc and always returns to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            state <= RUN;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= RUN;
        end else if (push) begin
`ifdef FETCH_HALT_ON_WRAP_EN
            // Fetching the last word ends the program; pc parks on it.
            if (pc == {ADDR_W{1'b1}}) begin
                state <= HALTED;
            end else begin
                pc <= pc + 1'b1;
            end
`else
            pc <= pc + 1'b1;
`endif
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data ({pc, rom_inst}),
        .rd_data (head),
        .count   (count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a behavioural combinational ROM.
// Stimulus pushes the expected {pc, inst} of every word the decoder should
// accept into a scoreboard queue; a monitor pops and compares on each
// accepted handshake. Cycle-exact checks cover latency, back-pressure,
// redirect, wrap (or halt with FETCH_HALT_ON_WRAP_EN) and async reset.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    import proc_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              fetch_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    logic [INST_W-1:0] rom [16];
    logic [ADDR_W+INST_W-1:0] sb_q [$];

    int tests_run = 0;
    int tests_failed = 0;

    instruction_fetch #(
        .ADDR_W     (ADDR_W),
        .INST_W     (INST_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_inst = rom[rom_addr];

    // Team program image.
    initial begin
        rom[0]  = {OP_ADDI, 4'h2, 4'h0, 4'h9};   // 16'h1209
        rom[1]  = {OP_ADDI, 4'h4, 4'h0, 4'h7};   // 16'h1407
        rom[2]  = 16'h2312;
        rom[3]  = 16'h3421;
        rom[4]  = {OP_OUT, 4'h3, 4'h0, 4'h0};
        rom[5]  = 16'h1501;
        rom[6]  = 16'h2553;
        rom[7]  = 16'hF500;
        rom[8]  = {OP_SUB, 4'hC, 4'h0, 4'h0};    // 16'h3C00
        rom[9]  = 16'h1101;
        rom[10] = {OP_ADD, 4'h1, 4'h1, 4'h2};
        rom[11] = 16'hF100;
        rom[12] = 16'h1A0F;
        rom[13] = 16'h2AA1;
        rom[14] = 16'h3AA2;
        rom[15] = 16'hFA00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fe, input logic rdy,
                                 input logic rv, input logic [ADDR_W-1:0] rpc);
        fetch_en       = fe;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectWord(input int p);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(p);
        sb_q.push_back({a, rom[a]});
    endtask

    // Monitor: every accepted handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_word: got pc %0d data 0x%0h, expected none",
                         inst_pc, inst_data);
            end else begin
                logic [ADDR_W+INST_W-1:0] exp_w;
                exp_w = sb_q.pop_front();
                if ({inst_pc, inst_data} !== exp_w) begin
                    tests_failed++;
                    $display("[TB] FAIL scoreboard: got pc %0d data 0x%0h, expected pc %0d data 0x%0h",
                             inst_pc, inst_data, exp_w[ADDR_W+INST_W-1:INST_W], exp_w[INST_W-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (2) tick();

        // Reset values.
        checkOutput("rst_valid",    32'(inst_valid), 0);
        checkOutput("rst_data",     32'(inst_data),  0);
        checkOutput("rst_pc",       32'(inst_pc),    0);
        checkOutput("rst_rom_addr", 32'(rom_addr),   0);
        checkOutput("rst_halted",   32'(halted),     0);

        // Streaming: pc 0..5 on consecutive cycles from the first edge.
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) expectWord(k);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("stream_valid", 32'(inst_valid), 1);
            checkOutput("stream_pc",    32'(inst_pc),    32'(k));
            if (k == 0) checkOutput("stream_data0", 32'(inst_data), 32'h1209);
            if (k == 1) checkOutput("stream_data1", 32'(inst_data), 32'h1407);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        checkOutput("freeze_valid",    32'(inst_valid), 0);
        checkOutput("freeze_rom_addr", 32'(rom_addr),   6);
        tick();
        checkOutput("freeze_hold",     32'(rom_addr),   6);

        // Back-pressure from pc 6, then async reset with the FIFO full.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        repeat (5) tick();
        checkOutput("full_rom_addr", 32'(rom_addr), 8);
        checkOutput("full_head_pc",  32'(inst_pc),  6);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid",    32'(inst_valid), 0);
        checkOutput("async_data",     32'(inst_data),  0);
        checkOutput("async_pc",       32'(inst_pc),    0);
        checkOutput("async_rom_addr", 32'(rom_addr),   0);
        tick();
        rst_n = 1'b1;
        sb_q.delete();

        // Five cycles with ready low: FIFO holds pc 0,1 and pc parks at 2.
        repeat (5) tick();
        checkOutput("sat_rom_addr", 32'(rom_addr),   2);
        checkOutput("sat_valid",    32'(inst_valid), 1);
        checkOutput("sat_head_pc",  32'(inst_pc),    0);
        for (int k = 0; k < 4; k++) expectWord(k);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        tick();
        tick();
        tick();
        checkOutput("pre_redirect_head", 32'(inst_pc), 3);

        // Redirect to 8 with pc 3,4 queued: 3 delivered now, 4 dropped.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd8);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("redirect_bubble", 32'(inst_valid), 0);
        checkOutput("redirect_pc_reg", 32'(rom_addr),   8);
        for (int k = 8; k < 16; k++) expectWord(k);
`ifndef FETCH_HALT_ON_WRAP_EN
        expectWord(0);
        expectWord(1);
`endif
        tick();
        checkOutput("target_pc",   32'(inst_pc),   8);
        checkOutput("target_data", 32'(inst_data), 32'h3C00);
        for (int k = 9; k < 16; k++) begin
            tick();
            checkOutput("run_pc", 32'(inst_pc), 32'(k));
        end
`ifndef FETCH_HALT_ON_WRAP_EN
        tick();
        checkOutput("wrap_pc0",    32'(inst_pc), 0);
        checkOutput("wrap_halted", 32'(halted),  0);
        tick();
        checkOutput("wrap_pc1",    32'(inst_pc), 1);
        checkOutput("wrap_halted", 32'(halted),  0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        checkOutput("wrap_drained", 32'(inst_valid), 0);
`else
        checkOutput("halt_set", 32'(halted), 1);
        tick();
        checkOutput("halt_drained",  32'(inst_valid), 0);
        checkOutput("halt_rom_addr", 32'(rom_addr),   15);
        tick();
        checkOutput("halt_no_fetch", 32'(inst_valid), 0);
        checkOutput("halt_hold",     32'(halted),     1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("halt_cleared", 32'(halted),     0);
        checkOutput("halt_bubble",  32'(inst_valid), 0);
        expectWord(0);
        tick();
        checkOutput("restart_valid", 32'(inst_valid), 1);
        checkOutput("restart_pc",    32'(inst_pc),    0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        checkOutput("restart_drained", 32'(inst_valid), 0);
`endif
        tick();
        checkOutput("scoreboard_left", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
